// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer that owns the HI/LO pair.
// One bit per cycle through a shared 33-bit accumulator; sign fix-up after the loop.
module muldiv_seq #(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [1:0]        op,
  input  logic [DATA_W-1:0] src_a,
  input  logic [DATA_W-1:0] src_b,
  input  logic              cancel,
  input  logic              mthi,
  input  logic              mtlo,
  input  logic [DATA_W-1:0] wdata,
  output logic              busy,
  output logic              done,
  output logic              div_by_zero,
  output logic [DATA_W-1:0] hi,
  output logic [DATA_W-1:0] lo
);

  localparam int CNT_W = $clog2(DATA_W);

  typedef enum logic [1:0] {IDLE, PREP, RUN, FIX} state_t;

  state_t            state;
  logic [CNT_W-1:0]  cnt;
  logic [DATA_W:0]   acc;     // product upper half / partial remainder
  logic [DATA_W-1:0] low;     // multiplier shifting out / quotient shifting in
  logic [DATA_W-1:0] opnd;    // multiplicand / divisor magnitude
  logic [DATA_W-1:0] a_raw;
  logic [DATA_W-1:0] b_raw;
  logic              is_div;
  logic              is_signed;
  logic              sign_q;
  logic              sign_r;

  logic [DATA_W-1:0]   mag_a;
  logic [DATA_W-1:0]   mag_b;
  logic [DATA_W:0]     rem_sh;
  logic [DATA_W+1:0]   trial;
  logic [DATA_W:0]     msum;
  logic [DATA_W:0]     madd;
  logic [2*DATA_W-1:0] prod;
  logic [2*DATA_W-1:0] prod_fix;
  logic [DATA_W-1:0]   quot_fix;
  logic [DATA_W-1:0]   rem_fix;

  // NOTE: every always_comb output gets a value on every path, so no latch is inferred.
  always_comb begin
    mag_a    = (is_signed && a_raw[DATA_W-1]) ? -a_raw : a_raw;
    mag_b    = (is_signed && b_raw[DATA_W-1]) ? -b_raw : b_raw;
    rem_sh   = {acc[DATA_W-1:0], low[DATA_W-1]};
    // Top bit of the widened subtract is the borrow: set when rem_sh < divisor.
    trial    = {1'b0, rem_sh} - {2'b00, opnd};
    msum     = acc + {1'b0, opnd};
    madd     = low[0] ? msum : acc;
    prod     = {acc[DATA_W-1:0], low};
    prod_fix = sign_q ? -prod : prod;
    quot_fix = sign_q ? -low : low;
    rem_fix  = sign_r ? -acc[DATA_W-1:0] : acc[DATA_W-1:0];
  end

  // NOTE: sequential state uses non-blocking assignments so all registers update together.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state       <= IDLE;
      cnt         <= '0;
      acc         <= '0;
      low         <= '0;
      opnd        <= '0;
      a_raw       <= '0;
      b_raw       <= '0;
      is_div      <= 1'b0;
      is_signed   <= 1'b0;
      sign_q      <= 1'b0;
      sign_r      <= 1'b0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      hi          <= '0;
      lo          <= '0;
    end else begin
      done        <= 1'b0;
      div_by_zero <= 1'b0;
      if (state != IDLE && cancel) begin
        state <= IDLE;
        busy  <= 1'b0;
      end else begin
        case (state)
          IDLE: begin
            if (mthi) hi <= wdata;
            if (mtlo) lo <= wdata;
            if (start && !cancel) begin
              a_raw     <= src_a;
              b_raw     <= src_b;
              is_div    <= op[1];
              is_signed <= ~op[0];
              busy      <= 1'b1;
              state     <= PREP;
            end
          end
          PREP: begin
            low    <= is_div ? mag_a : mag_b;
            opnd   <= is_div ? mag_b : mag_a;
            acc    <= '0;
            sign_q <= is_signed & (a_raw[DATA_W-1] ^ b_raw[DATA_W-1]);
            sign_r <= is_signed & a_raw[DATA_W-1];
            cnt    <= CNT_W'(DATA_W - 1);
            state  <= RUN;
          end
          RUN: begin
            if (is_div) begin
              if (!trial[DATA_W+1]) begin
                acc <= trial[DATA_W:0];
                low <= {low[DATA_W-2:0], 1'b1};
              end else begin
                acc <= rem_sh;
                low <= {low[DATA_W-2:0], 1'b0};
              end
            end else begin
              acc <= {1'b0, madd[DATA_W:1]};
              low <= {madd[0], low[DATA_W-1:1]};
            end
            cnt <= cnt - 1'b1;
            if (cnt == '0) state <= FIX;
          end
          FIX: begin
            busy  <= 1'b0;
            done  <= 1'b1;
            state <= IDLE;
            if (!is_div) begin
              hi <= prod_fix[2*DATA_W-1:DATA_W];
              lo <= prod_fix[DATA_W-1:0];
            end else if (b_raw == '0) begin
              lo          <= '1;
              hi          <= a_raw;
              div_by_zero <= 1'b1;
            end else begin
              lo <= quot_fix;
              hi <= rem_fix;
            end
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Scoreboard bench for muldiv_seq: issued ops push expected HI/LO, a monitor pops on done.
module tb_muldiv_seq;

  typedef struct {
    logic [31:0] hi;
    logic [31:0] lo;
    logic        dbz;
  } exp_t;

  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [1:0]  op;
  logic [31:0] src_a;
  logic [31:0] src_b;
  logic        cancel;
  logic        mthi;
  logic        mtlo;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic        div_by_zero;
  logic [31:0] hi;
  logic [31:0] lo;

  int   checks   = 0;
  int   failures = 0;
  int   done_cnt = 0;
  exp_t exp_q[$];

  muldiv_seq #(.DATA_W(32)) dut (
    .clk(clk), .reset(reset), .start(start), .op(op),
    .src_a(src_a), .src_b(src_b), .cancel(cancel),
    .mthi(mthi), .mtlo(mtlo), .wdata(wdata),
    .busy(busy), .done(done), .div_by_zero(div_by_zero),
    .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp_v);
    end
  endtask

  // Reference model from the arithmetic definitions of each op.
  function automatic exp_t model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    exp_t    e;
    longint  sa, sb;
    longint unsigned ua, ub;
    logic [63:0] p, q, r;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    e.dbz = 1'b0;
    case (o)
      2'b00: begin p = sa * sb; e.hi = p[63:32]; e.lo = p[31:0]; end
      2'b01: begin p = ua * ub; e.hi = p[63:32]; e.lo = p[31:0]; end
      default: begin
        if (b == 32'h0) begin
          e.lo = 32'hFFFF_FFFF; e.hi = a; e.dbz = 1'b1;
        end else if (o == 2'b10) begin
          q = sa / sb; r = sa % sb; e.lo = q[31:0]; e.hi = r[31:0];
        end else begin
          q = ua / ub; r = ua % ub; e.lo = q[31:0]; e.hi = r[31:0];
        end
      end
    endcase
    return e;
  endfunction

  // Monitor: every done pulse must match the oldest outstanding expectation.
  always @(negedge clk) begin
    if (!reset && done) begin
      exp_t e;
      done_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: got done=1 expected no pulse");
      end else begin
        e = exp_q.pop_front();
        check("result_hi", {32'b0, hi}, {32'b0, e.hi});
        check("result_lo", {32'b0, lo}, {32'b0, e.lo});
        check("div_by_zero", {63'b0, div_by_zero}, {63'b0, e.dbz});
      end
    end
  end

  // Issue one op; optionally a stray start / mthi / cancel sampled at edge E<n> (-1 = none).
  task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                        input int extra_start_at, input int mthi_at, input int cancel_at);
    int          dc0, lat, busy_low;
    logic [31:0] hi0, lo0;
    bit          got;
    @(posedge clk); #1;
    hi0 = hi; lo0 = lo; dc0 = done_cnt;
    op = o; src_a = a; src_b = b; start = 1'b1;
    if (mthi_at == 0) begin mthi = 1'b1; wdata = 32'hC0DE_1234; end
    if (cancel_at < 0) exp_q.push_back(model(o, a, b));
    @(posedge clk); #1;
    start = 1'b0; mthi = 1'b0;
    check("busy_after_e0", {63'b0, busy}, 64'd1);
    if (mthi_at == 0) check("mthi_with_start", {32'b0, hi}, {32'b0, 32'hC0DE_1234});
    got = 1'b0; lat = 0; busy_low = 0;
    for (int i = 1; i <= 40 && !got; i++) begin
      start  = (i == extra_start_at);
      if (start) begin op = ~o; src_a = $urandom; src_b = $urandom; end
      mthi   = (i == mthi_at);
      wdata  = 32'h0000_1234;
      cancel = (i == cancel_at);
      @(posedge clk); #1;
      start = 1'b0; mthi = 1'b0; cancel = 1'b0;
      if (i == mthi_at) check("mthi_ignored_busy", {32'b0, hi}, {32'b0, hi0});
      if (i == cancel_at) begin
        check("busy_after_cancel", {63'b0, busy}, 64'd0);
        got = 1'b1;
      end else if (done) begin
        got = 1'b1; lat = i;
        check("busy_in_done_cycle", {63'b0, busy}, 64'd0);
      end else if (!busy) begin
        busy_low++;
      end
    end
    if (cancel_at >= 0) begin
      repeat (40) @(posedge clk);
      #1;
      check("no_done_after_cancel", 64'(done_cnt), 64'(dc0));
      check("hi_kept_cancel", {32'b0, hi}, {32'b0, hi0});
      check("lo_kept_cancel", {32'b0, lo}, {32'b0, lo0});
    end else begin
      check("done_seen", {63'b0, got}, 64'd1);
      check("latency", 64'(lat), 64'd34);
      check("busy_gaps", 64'(busy_low), 64'd0);
      repeat (3) @(posedge clk);
      #1;
      check("one_done_pulse", 64'(done_cnt), 64'(dc0 + 1));
    end
  endtask

  function automatic logic [31:0] pick();
    case ($urandom_range(0, 6))
      0: return 32'h0;
      1: return 32'h1;
      2: return 32'hFFFF_FFFF;
      3: return 32'h8000_0000;
      4: return $urandom_range(1, 20);
      default: return $urandom;
    endcase
  endfunction

  initial begin
    reset = 1'b1; start = 1'b0; op = 2'b00; src_a = '0; src_b = '0;
    cancel = 1'b0; mthi = 1'b0; mtlo = 1'b0; wdata = '0;
    repeat (2) @(posedge clk);
    #1;
    check("reset_busy", {63'b0, busy}, 64'd0);
    check("reset_done", {63'b0, done}, 64'd0);
    check("reset_dbz", {63'b0, div_by_zero}, 64'd0);
    check("reset_hilo", {hi, lo}, 64'd0);
    reset = 1'b0;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, -1, -1, -1);
    check("multu_max_hilo", {hi, lo}, 64'hFFFF_FFFE_0000_0001);
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, -1, -1, -1);
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, -1, -1, -1);
    run_op(2'b11, 32'd7, 32'd2, -1, -1, -1);
    check("divu_7_2", {hi, lo}, {32'd1, 32'd3});
    run_op(2'b11, 32'd100, 32'd0, -1, -1, -1);
    check("divu_by_zero", {hi, lo}, {32'd100, 32'hFFFF_FFFF});
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, -1, -1, -1);
    check("div_overflow", {hi, lo}, {32'd0, 32'h8000_0000});

    run_op(2'b00, 32'd12345, 32'hFFFF_FD4A, 5, 10, -1);

    @(posedge clk); #1;
    mthi = 1'b1; wdata = 32'h0000_AAAA;
    @(posedge clk); #1;
    mthi = 1'b0; mtlo = 1'b1; wdata = 32'h0000_5555;
    @(posedge clk); #1;
    mtlo = 1'b0;
    check("preload_hilo", {hi, lo}, {32'h0000_AAAA, 32'h0000_5555});
    run_op(2'b10, 32'd1000, 32'd7, -1, -1, 13);
    run_op(2'b10, 32'd1000, 32'd7, -1, -1, -1);
    run_op(2'b01, 32'h0001_0000, 32'h0003_0000, -1, 0, -1);

    // Asynchronous reset mid-RUN, between clock edges.
    @(posedge clk); #1;
    op = 2'b01; src_a = 32'hDEAD_BEEF; src_b = 32'h1234_5678; start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (15) @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    check("async_reset_busy", {63'b0, busy}, 64'd0);
    check("async_reset_done", {63'b0, done}, 64'd0);
    check("async_reset_hilo", {hi, lo}, 64'd0);
    @(posedge clk); #3;
    reset = 1'b0;
    run_op(2'b01, 32'd2, 32'd3, -1, -1, -1);
    check("multu_2x3_lo", {32'b0, lo}, 64'd6);

    for (int n = 0; n < 40; n++) begin
      logic [1:0]  o;
      logic [31:0] a, b;
      o = 2'($urandom_range(0, 3));
      a = pick();
      b = pick();
      run_op(o, a, b, -1, -1, -1);
    end

    check("scoreboard_drained", 64'(exp_q.size()), 64'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
